// File: rtl/qbuff_pkg.sv
// Shared types and helpers for the qbuff capture controller.
package qbuff_pkg;

    // One-hot so each state decodes to a single flop.
    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        ARM   = 6'b000010,
        REQ   = 6'b000100,
        REL   = 6'b001000,
        ABORT = 6'b010000,
        DONE  = 6'b100000
    } ctrl_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // A zero-sample capture would still consume a header word, so treat it as one sample.
    function automatic int unsigned clamp_nsamp(input int unsigned nsamp);
        return (nsamp == 0) ? 1 : nsamp;
    endfunction

endpackage

// File: rtl/qbuff_trig_sync.sv
// Brings the asynchronous trigger into aclk and emits a one-cycle pulse per rising edge.
module qbuff_trig_sync
    import qbuff_pkg::*;
(
    input  logic aclk,
    input  logic aresetn,
    input  logic trig,
    output logic trig_ev
);

    logic [SYNC_STAGES:0] sync_sh;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_sh <= '0;
            trig_ev <= 1'b0;
        end else begin
            sync_sh <= {sync_sh[SYNC_STAGES-1:0], trig};
            trig_ev <= sync_sh[SYNC_STAGES-1] & ~sync_sh[SYNC_STAGES];
        end
    end

endmodule

// File: rtl/qbuff_capture_ctrl.sv
// Sequences the qbuff write engine: arm, trigger-driven capture requests, quota and capacity limits.
module qbuff_capture_ctrl
    import qbuff_pkg::*;
#(
    parameter int N = 4,
    parameter int B = 8
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           trig,
    input  logic           START_REG,
    input  logic [N-1:0]   NSAMP_REG,
    input  logic [N-1:0]   NCAPT_REG,
    output logic           wr_start,
    output logic           wr_write,
    input  logic           wr_ack,
    output logic [2*B-1:0] wr_ttag,
    output logic [N-1:0]   wr_nsamp,
    output logic           busy,
    output logic           done,
    output logic           full,
    output logic [N-1:0]   capt_cnt,
    output logic [N-1:0]   miss_cnt
);

    localparam int UW = N + 1;
    localparam int SW = N + 2;
    localparam logic [N+1:0] CAP = SW'(1) << N;

    ctrl_state_t    state;
    logic           start_r;
    logic           start_d;
    logic           st_rise;
    logic           trig_ev;
    logic [2*B-1:0] ttag_cnt;
    logic [N-1:0]   nsamp_r;
    logic [N-1:0]   ncapt_r;
    logic [N:0]     used;
    logic [N:0]     need;
    logic [N+1:0]   after_capt;
    logic           fits;

    qbuff_trig_sync u_trig_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .trig    (trig),
        .trig_ev (trig_ev)
    );

    // Each capture stores its samples plus one time-tag word.
    assign need       = UW'(nsamp_r) + 1'b1;
    assign after_capt = SW'(used) + SW'(need);
    assign fits       = (after_capt <= CAP);
    assign st_rise    = start_r & ~start_d;

    assign wr_start = (state == ARM) || (state == REQ) || (state == REL) || (state == DONE);
    assign wr_write = (state == REQ);
    assign busy     = (state == ARM) || (state == REQ) || (state == REL) || (state == ABORT);
    assign wr_nsamp = nsamp_r;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            start_r  <= 1'b0;
            start_d  <= 1'b0;
            ttag_cnt <= '0;
        end else begin
            start_r  <= START_REG;
            start_d  <= start_r;
            ttag_cnt <= st_rise ? '0 : ttag_cnt + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= IDLE;
            nsamp_r  <= '0;
            ncapt_r  <= '0;
            used     <= '0;
            capt_cnt <= '0;
            miss_cnt <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
            wr_ttag  <= '0;
        end else begin
            if (trig_ev && start_r && (state != ARM) && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (st_rise) begin
                        nsamp_r  <= N'(clamp_nsamp(32'(NSAMP_REG)));
                        ncapt_r  <= NCAPT_REG;
                        used     <= '0;
                        capt_cnt <= '0;
                        miss_cnt <= '0;
                        done     <= 1'b0;
                        full     <= 1'b0;
                        state    <= ARM;
                    end
                end
                ARM: begin
                    if (!start_r) begin
                        state <= IDLE;
                    end else if (trig_ev) begin
                        if (fits) begin
                            wr_ttag <= ttag_cnt;
                            state   <= REQ;
                        end else begin
                            full  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (!start_r) begin
                        state <= ABORT;
                    end else if (wr_ack) begin
                        used     <= used + need;
                        capt_cnt <= capt_cnt + 1'b1;
                        state    <= REL;
                    end
                end
                REL: begin
                    if (!start_r) begin
                        state <= ABORT;
                    end else if (!wr_ack) begin
                        if ((ncapt_r != '0) && (capt_cnt == ncapt_r)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                // The engine may still be mid-burst; let it drop ack before re-arming.
                ABORT: begin
                    if (!wr_ack)
                        state <= IDLE;
                end
                DONE: begin
                    if (!start_r)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qbuff_capture_ctrl.sv
// Directed bench for qbuff_capture_ctrl: quota, capacity, time-tag, miss counting, abort and reset.
module tb_qbuff_capture_ctrl;

    localparam int N = 4;
    localparam int B = 8;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic           trig;
    logic           start_reg;
    logic [N-1:0]   nsamp_reg;
    logic [N-1:0]   ncapt_reg;
    logic           wr_start;
    logic           wr_write;
    logic           wr_ack;
    logic [2*B-1:0] wr_ttag;
    logic [N-1:0]   wr_nsamp;
    logic           busy;
    logic           done;
    logic           full;
    logic [N-1:0]   capt_cnt;
    logic [N-1:0]   miss_cnt;

    int errors = 0;
    int checks = 0;

    qbuff_capture_ctrl #(.N(N), .B(B)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .trig      (trig),
        .START_REG (start_reg),
        .NSAMP_REG (nsamp_reg),
        .NCAPT_REG (ncapt_reg),
        .wr_start  (wr_start),
        .wr_write  (wr_write),
        .wr_ack    (wr_ack),
        .wr_ttag   (wr_ttag),
        .wr_nsamp  (wr_nsamp),
        .busy      (busy),
        .done      (done),
        .full      (full),
        .capt_cnt  (capt_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_write(input logic level, input string tag);
        int n = 0;
        while (wr_write !== level && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check(tag, 32'(wr_write), 32'(level));
    endtask

    // Rising edge reaches the FSM four clock edges after trig is driven.
    task automatic pulse_trig();
        trig = 1'b1;
        repeat (2) @(negedge aclk);
        trig = 1'b0;
        repeat (3) @(negedge aclk);
    endtask

    task automatic capture(input string tag);
        wait_write(1'b1, {tag, "_req"});
        wr_ack = 1'b1;
        @(negedge aclk);
        wait_write(1'b0, {tag, "_rel"});
        wr_ack = 1'b0;
        @(negedge aclk);
    endtask

    task automatic restart(input logic [N-1:0] nsamp, input logic [N-1:0] ncapt);
        start_reg = 1'b0;
        repeat (3) @(negedge aclk);
        nsamp_reg = nsamp;
        ncapt_reg = ncapt;
        start_reg = 1'b1;
        repeat (3) @(negedge aclk);
    endtask

    initial begin
        aresetn   = 1'b0;
        trig      = 1'b0;
        start_reg = 1'b0;
        nsamp_reg = '0;
        ncapt_reg = '0;
        wr_ack    = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_start", 32'(wr_start), 0);
        check("rst_write", 32'(wr_write), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_ttag",  32'(wr_ttag), 0);
        check("rst_nsamp", 32'(wr_nsamp), 0);
        check("rst_capt",  32'(capt_cnt), 0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Quota of two captures, four words each.
        restart(4'd3, 4'd2);
        check("t1_armed", 32'(wr_start), 1);
        check("t1_nsamp", 32'(wr_nsamp), 3);
        pulse_trig();
        capture("t1_c1");
        check("t1_capt1", 32'(capt_cnt), 1);
        check("t1_done1", 32'(done), 0);
        pulse_trig();
        capture("t1_c2");
        check("t1_capt2", 32'(capt_cnt), 2);
        check("t1_done",  32'(done), 1);
        check("t1_full",  32'(full), 0);
        check("t1_used",  32'(dut.used), 8);
        check("t1_busy",  32'(busy), 0);
        check("t1_start", 32'(wr_start), 1);

        // Unlimited quota, eight words each: two fit exactly, the third overflows.
        restart(4'd7, 4'd0);
        check("t2_clr_done", 32'(done), 0);
        pulse_trig();
        capture("t2_c1");
        pulse_trig();
        capture("t2_c2");
        check("t2_used", 32'(dut.used), 16);
        check("t2_full0", 32'(full), 0);
        pulse_trig();
        @(negedge aclk);
        check("t2_full",  32'(full), 1);
        check("t2_nowr",  32'(wr_write), 0);
        check("t2_done",  32'(done), 0);
        check("t2_capt",  32'(capt_cnt), 2);
        pulse_trig();
        pulse_trig();
        check("t2_miss",  32'(miss_cnt), 2);

        // Time-tag: trig driven between edges 98 and 99 after START rises yields tag 100.
        start_reg = 1'b0;
        repeat (3) @(negedge aclk);
        nsamp_reg = 4'd2;
        ncapt_reg = 4'd0;
        start_reg = 1'b1;
        repeat (99) @(negedge aclk);
        trig = 1'b1;
        repeat (2) @(negedge aclk);
        trig = 1'b0;
        wait_write(1'b1, "t3_req");
        check("t3_ttag", 32'(wr_ttag), 100);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check("t3_ttag_hold", 32'(wr_ttag), 100);
        end
        check("t3_still_req", 32'(wr_write), 1);
        wr_ack = 1'b1;
        @(negedge aclk);
        wait_write(1'b0, "t3_rel");
        check("t3_ttag_rel", 32'(wr_ttag), 100);
        wr_ack = 1'b0;
        @(negedge aclk);
        check("t3_capt", 32'(capt_cnt), 1);

        // Triggers arriving while a request is outstanding are counted as misses.
        pulse_trig();
        check("t4_req", 32'(wr_write), 1);
        for (int i = 0; i < 3; i++) pulse_trig();
        check("t4_miss", 32'(miss_cnt), 3);
        check("t4_capt", 32'(capt_cnt), 1);
        check("t4_write", 32'(wr_write), 1);
        capture("t4_c");
        check("t4_capt2", 32'(capt_cnt), 2);

        // START dropped while a request is pending and the engine acknowledges.
        pulse_trig();
        check("t5_req", 32'(wr_write), 1);
        start_reg = 1'b0;
        @(negedge aclk);
        wr_ack = 1'b1;
        @(negedge aclk);
        check("t5_abort_wr",    32'(wr_write), 0);
        check("t5_abort_start", 32'(wr_start), 0);
        check("t5_abort_busy",  32'(busy), 1);
        repeat (3) @(negedge aclk);
        check("t5_wait_ack", 32'(busy), 1);
        wr_ack = 1'b0;
        @(negedge aclk);
        check("t5_idle_busy",  32'(busy), 0);
        check("t5_idle_start", 32'(wr_start), 0);

        // Zero sample count clamps to one; reset mid-request clears everything.
        nsamp_reg = 4'd0;
        ncapt_reg = 4'd0;
        start_reg = 1'b1;
        repeat (3) @(negedge aclk);
        check("t6_nsamp", 32'(wr_nsamp), 1);
        check("t6_miss_clr", 32'(miss_cnt), 0);
        check("t6_capt_clr", 32'(capt_cnt), 0);
        pulse_trig();
        check("t6_req", 32'(wr_write), 1);
        aresetn = 1'b0;
        @(negedge aclk);
        check("t6_rst_start", 32'(wr_start), 0);
        check("t6_rst_write", 32'(wr_write), 0);
        check("t6_rst_ttag",  32'(wr_ttag), 0);
        check("t6_rst_nsamp", 32'(wr_nsamp), 0);
        check("t6_rst_busy",  32'(busy), 0);
        check("t6_rst_done",  32'(done), 0);
        check("t6_rst_full",  32'(full), 0);
        check("t6_rst_capt",  32'(capt_cnt), 0);
        check("t6_rst_miss",  32'(miss_cnt), 0);
        aresetn   = 1'b1;
        start_reg = 1'b0;
        repeat (2) @(negedge aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
